// File: rtl/matrix_stream_loader.sv
// Stream-to-matrix front end: collects A then B elements from a valid/ready stream
// and presents a complete frame as packed A/B buses with a one-cycle vout pulse.
module matrix_stream_loader #(
    parameter int unsigned dsize = 8,
    parameter int unsigned rowsA = 10,
    parameter int unsigned colsA = 10,
    parameter int unsigned rowsB = 10,
    parameter int unsigned colsB = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [dsize-1:0]               s_data,
    input  logic                           s_valid,
    input  logic                           s_last,
    output logic                           s_ready,
    output logic                           vout,
    output logic [rowsA*colsA*dsize-1:0]   A,
    output logic [rowsB*colsB*dsize-1:0]   B,
    output logic                           err
);

    localparam int unsigned NA   = rowsA * colsA;
    localparam int unsigned NB   = rowsB * colsB;
    localparam int unsigned NMAX = (NA > NB) ? NA : NB;
    localparam int unsigned IW   = (NMAX > 1) ? $clog2(NMAX) : 1;

    typedef enum logic {
        LOAD_A = 1'b0,
        LOAD_B = 1'b1
    } state_t;

    state_t                     state;
    logic [IW-1:0]              idx;
    logic [NA-1:0][dsize-1:0]   asm_a;
    logic [NB-1:0][dsize-1:0]   asm_b;
    logic [NB-1:0][dsize-1:0]   b_merged;
    logic                       accept;
    logic                       last_a;
    logic                       last_b;
    logic                       wr_a;
    logic                       wr_b;

    assign accept = s_valid && s_ready;
    assign last_a = (idx == IW'(NA - 1));
    assign last_b = (idx == IW'(NB - 1));
    assign wr_a   = accept && (state == LOAD_A);
    assign wr_b   = accept && (state == LOAD_B);

    // The final B element goes straight to the output register, bypassing assembly.
    always_comb begin
        b_merged         = asm_b;
        b_merged[NB-1]   = s_data;
    end

    // Per-element assembly registers; a discarded partial frame may leave stale data.
    for (genvar e = 0; e < NA; e++) begin : g_asm_a
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                asm_a[e] <= '0;
            end else if (wr_a && (idx == IW'(e))) begin
                asm_a[e] <= s_data;
            end
        end
    end

    for (genvar e = 0; e < NB; e++) begin : g_asm_b
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                asm_b[e] <= '0;
            end else if (wr_b && (idx == IW'(e))) begin
                asm_b[e] <= s_data;
            end
        end
    end

    // Frame sequencing, framing checks and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= LOAD_A;
            idx     <= '0;
            s_ready <= 1'b0;
            vout    <= 1'b0;
            err     <= 1'b0;
            A       <= '0;
            B       <= '0;
        end else begin
            s_ready <= 1'b1;
            vout    <= 1'b0;
            err     <= 1'b0;
            if (accept) begin
                unique case (state)
                    LOAD_A: begin
                        if (s_last) begin
                            err <= 1'b1;
                            idx <= '0;
                        end else if (last_a) begin
                            idx   <= '0;
                            state <= LOAD_B;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                    LOAD_B: begin
                        if (last_b) begin
                            if (s_last) begin
                                A    <= asm_a;
                                B    <= b_merged;
                                vout <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                            idx   <= '0;
                            state <= LOAD_A;
                        end else if (s_last) begin
                            err   <= 1'b1;
                            idx   <= '0;
                            state <= LOAD_A;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                    default: begin
                        idx   <= '0;
                        state <= LOAD_A;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/matrix_stream_loader.md
Name: matrix_stream_loader

Overview:
- Front-end feeder for the pipelined matrix multiplier.
- Accepts matrix elements one per beat on a valid/ready stream: all of A row-major, then all of B row-major.
- Packs the elements into the flat A/B bus layout the multiplier consumes.
- Issues a single-cycle valid pulse per completed frame, so it drives the multiplier's vin.

Parameters:
- dsize, 8, element width in bits.
- rowsA, 10, rows of A.
- colsA, 10, columns of A; equals rowsB.
- rowsB, 10, rows of B.
- colsB, 10, columns of B.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- s_data  input  dsize  element value.
- s_valid  input  1  s_data valid.
- s_last  input  1  marks the final element of a frame (last B element).
- s_ready  output  1  loader can accept a beat.
- vout  output  1  one-cycle pulse; A/B hold a new complete frame. Connects to multiplier vin.
- A  output  rowsA*colsA*dsize  packed A; element (m,k) at bits ((m*colsA+k)+1)*dsize-1 -: dsize.
- B  output  rowsB*colsB*dsize  packed B; element (k,n) at bits ((k*colsB+n)+1)*dsize-1 -: dsize.
- err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (rst low, asynchronous):
  - s_ready=0, vout=0, err=0.
  - A, B output registers = 0.
  - Assembly registers = 0.
  - Element index = 0; state = LOAD_A.
- After rst deasserts, s_ready=1 from the first clock edge onward. s_ready stays 1 in all states (no backpressure).
- Beat accepted when s_valid && s_ready at a rising edge. No beat is accepted while s_ready=0.
- State machine: LOAD_A -> LOAD_B -> LOAD_A.
  - LOAD_A: beat idx i (0..rowsA*colsA-1) writes assembly-A element (i/colsA, i%colsA).
    - On the last A index, go to LOAD_B with idx=0.
  - LOAD_B: beat idx j (0..rowsB*colsB-1) writes assembly-B element (j/colsB, j%colsB).
- Frame completion: final B beat accepted with s_last=1.
  - At that same edge, output A <= assembly A, and output B <= assembly B with the final element merged in.
  - vout=1 for exactly the following cycle.
  - State returns to LOAD_A, idx=0.
- Latency: vout asserts 1 cycle after the last beat's accepting edge. A/B are valid in the same cycle as vout.
- A/B outputs hold their values until the next completed frame. Beats of a new frame never disturb the outputs, so back-to-back frames with no idle cycles are legal.
- Framing errors (either case):
  - s_last=1 on any beat other than the final B beat, or
  - final B beat accepted with s_last=0.
  - Response: err=1 for the next cycle; the partial frame is discarded; A/B and vout are unchanged (no pulse); state -> LOAD_A, idx=0.
  - Assembly registers need not be cleared.
- s_valid=0 cycles (gaps) anywhere in a frame: state and idx hold; no side effects.
- s_data and s_last are don't-care when s_valid=0.
- Reset mid-frame: the partial frame is lost and all outputs return to their reset values immediately (asynchronous).
- vout and err are never both 1 in the same cycle.
- Arithmetic: idx counters wide enough for max(rowsA*colsA, rowsB*colsB). No data arithmetic; elements are stored verbatim.

Test Plan:
- Directed scenarios use dsize=8 and 2x2 matrices.
- 1. Reset: hold rst=0 with s_valid=1 -> s_ready=0, vout=0, err=0, A=B=0; release -> s_ready=1 next edge.
- 2. Single frame: stream A=1,2,3,4 then B=5,6,7,8 with s_last on the 8th beat -> one cycle later vout=1, A=0x04030201, B=0x08070605; vout=0 the cycle after.
- 3. Gaps: same frame with s_valid low for 3 cycles after beats 2 and 6 -> identical A/B; vout 1 cycle after the 8th accepted beat; no early pulse.
- 4. Back-to-back: two frames with no idle cycle (second frame A=9..12, B=13..16) -> two vout pulses 8 cycles apart; first A/B holds until the second pulse, then A=0x0C0B0A09, B=0x100F0E0D.
- 5. Early s_last on beat 3 -> err pulse; no vout; A/B unchanged. A following correct frame loads normally.
- 6. Missing s_last on beat 8 -> err pulse, no vout. Asserting rst mid-frame after beat 5 -> outputs zero at once; the next full frame loads correctly.
